// File: rtl/aes_axis_out_serializer.sv
// AES output stage: buffers 128-bit result blocks in a small FIFO and serializes
// each block into four 32-bit AXI-Stream beats, most significant word first.
module aes_axis_out_serializer #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int BLOCK_WIDTH          = 128,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_areset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BLOCK_WIDTH-1:0]              in_block,
    input  logic                                in_last,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    output logic [15:0]                         blocks_sent
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam int DW = C_M_AXIS_TDATA_WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [BLOCK_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW:0]          count;
    logic [1:0]           word_idx;
    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 beat_fire;
    logic [BLOCK_WIDTH:0] head;
    logic [DW-1:0]        word;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    // No push-through at full: a same-cycle pop does not open in_ready.
    assign in_ready  = !full && !m00_axis_areset;
    assign push      = in_valid && in_ready;
    assign beat_fire = m00_axis_tvalid && m00_axis_tready;
    assign pop       = beat_fire && (word_idx == 2'd3);
    assign head      = mem[rd_ptr[AW-1:0]];

    always_comb begin
        word = '0;
        case (word_idx)
            2'd0:    word = head[BLOCK_WIDTH-1 -: DW];
            2'd1:    word = head[BLOCK_WIDTH-1-DW -: DW];
            2'd2:    word = head[BLOCK_WIDTH-1-2*DW -: DW];
            default: word = head[BLOCK_WIDTH-1-3*DW -: DW];
        endcase
    end

    // Outputs are gated with tvalid so unwritten storage never leaks onto the bus.
    assign m00_axis_tvalid = !empty;
    assign m00_axis_tdata  = m00_axis_tvalid ? word : '0;
    assign m00_axis_tlast  = m00_axis_tvalid && head[BLOCK_WIDTH] && (word_idx == 2'd3);
    assign m00_axis_tstrb  = '1;

    always_ff @(posedge m00_axis_aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_last, in_block};
        end
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            word_idx    <= '0;
            blocks_sent <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (beat_fire) begin
                word_idx <= word_idx + 2'd1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                blocks_sent <= blocks_sent + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!empty) state_nxt = ST_SEND;
            default: if (pop && !push && (count == (AW+1)'(1))) state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

endmodule

// File: tb/tb_aes_axis_out_serializer.sv
// Directed bench for aes_axis_out_serializer: beat order, tlast placement,
// backpressure, full FIFO, pointer wrap and mid-packet reset.
module tb_aes_axis_out_serializer;

    logic         clk = 1'b0;
    logic         areset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         in_last;
    logic         tvalid;
    logic         tready;
    logic [31:0]  tdata;
    logic [3:0]   tstrb;
    logic         tlast;
    logic [15:0]  blocks_sent;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    aes_axis_out_serializer #(
        .C_M_AXIS_TDATA_WIDTH(32),
        .BLOCK_WIDTH(128),
        .FIFO_DEPTH(4)
    ) dut (
        .m00_axis_aclk(clk),
        .m00_axis_areset(areset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_block(in_block),
        .in_last(in_last),
        .m00_axis_tvalid(tvalid),
        .m00_axis_tready(tready),
        .m00_axis_tdata(tdata),
        .m00_axis_tstrb(tstrb),
        .m00_axis_tlast(tlast),
        .blocks_sent(blocks_sent)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wrd(input logic [127:0] blk, input int unsigned i);
        return blk[127 - 32*i -: 32];
    endfunction

    function automatic logic [127:0] pat(input int unsigned n);
        logic [31:0] b;
        b = 32'hC0DE0000 + n * 4;
        return {b, b + 32'd1, b + 32'd2, b + 32'd3};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d, input logic l);
        @(negedge clk);
        chk({tag, "_tvalid"}, tvalid, 1'b1);
        chk({tag, "_tdata"}, tdata, d);
        chk({tag, "_tlast"}, tlast, l);
        next_cycle();
    endtask

    task automatic push_blk(input logic [127:0] blk, input logic l);
        in_valid = 1'b1;
        in_block = blk;
        in_last  = l;
        @(negedge clk);
        chk("push_ready", in_ready, 1'b1);
        next_cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] a, b, c, d, e, g, h;
        logic [127:0] f [5];
        logic [1:0]   bp_pat;
        int unsigned  k, pushed, got, cyc;

        areset   = 1'b1;
        in_valid = 1'b0;
        in_block = '0;
        in_last  = 1'b0;
        tready   = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_blocks", blocks_sent, 16'h0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("tstrb", tstrb, 4'hF);
        next_cycle();
        areset = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1'b1);
        next_cycle();

        // Single block, tready high
        tready = 1'b1;
        a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        push_blk(a, 1'b1);
        expect_beat("s0", 32'h00112233, 1'b0);
        expect_beat("s1", 32'h44556677, 1'b0);
        expect_beat("s2", 32'h8899AABB, 1'b0);
        expect_beat("s3", 32'hCCDDEEFF, 1'b1);
        @(negedge clk);
        chk("s_idle", tvalid, 1'b0);
        chk("s_blocks", blocks_sent, 16'd1);
        next_cycle();

        // Three-block packet, back-to-back beats
        a = 128'hA0000000_A0000001_A0000002_A0000003;
        b = 128'hB0000000_B0000001_B0000002_B0000003;
        c = 128'hC0000000_C0000001_C0000002_C0000003;
        in_valid = 1'b1; in_block = a; in_last = 1'b0;
        next_cycle();
        in_block = b;
        expect_beat("p_a0", wrd(a, 0), 1'b0);
        in_block = c; in_last = 1'b1;
        expect_beat("p_a1", wrd(a, 1), 1'b0);
        in_valid = 1'b0; in_last = 1'b0;
        expect_beat("p_a2", wrd(a, 2), 1'b0);
        expect_beat("p_a3", wrd(a, 3), 1'b0);
        for (int unsigned i = 0; i < 4; i++) expect_beat("p_b", wrd(b, i), 1'b0);
        for (int unsigned i = 0; i < 4; i++) expect_beat("p_c", wrd(c, i), i == 3);
        @(negedge clk);
        chk("p_idle", tvalid, 1'b0);
        chk("p_blocks", blocks_sent, 16'd4);
        next_cycle();

        // Backpressure: tready 1,0,0,1 repeating over two blocks
        tready = 1'b0;
        d = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
        e = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;
        push_blk(d, 1'b0);
        push_blk(e, 1'b1);
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 40) begin
            bp_pat = cyc[1:0];
            tready = (bp_pat == 2'd0) || (bp_pat == 2'd3);
            @(negedge clk);
            chk("bp_tvalid", tvalid, 1'b1);
            chk("bp_tdata", tdata, (k < 4) ? wrd(d, k) : wrd(e, k - 4));
            chk("bp_tlast", tlast, k == 7);
            if (tready) k++;
            cyc++;
            next_cycle();
        end
        chk("bp_beats", k, 8);
        tready = 1'b0;
        @(negedge clk);
        chk("bp_idle", tvalid, 1'b0);
        chk("bp_blocks", blocks_sent, 16'd6);
        next_cycle();

        // Full FIFO: five blocks offered with tready low
        for (int unsigned i = 0; i < 5; i++) f[i] = {4{32'hF0000000 + i}};
        for (int unsigned i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_block = f[i]; in_last = (i == 4);
            @(negedge clk);
            chk("full_in_ready", in_ready, i < 4);
            if (i < 4) next_cycle();
        end
        chk("full_tdata", tdata, wrd(f[0], 0));
        next_cycle();
        tready = 1'b1;
        for (int unsigned j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("full_drain_tdata", tdata, wrd(f[0], j));
            chk("full_no_pass", in_ready, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        chk("full_reopen", in_ready, 1'b1);
        chk("full_f1w0", tdata, wrd(f[1], 0));
        next_cycle();
        in_valid = 1'b0; in_last = 1'b0;
        for (int unsigned j = 1; j < 4; j++) expect_beat("full_f1", wrd(f[1], j), 1'b0);
        for (int unsigned i = 2; i < 5; i++)
            for (int unsigned j = 0; j < 4; j++) expect_beat("full_fn", wrd(f[i], j), (i == 4) && (j == 3));
        @(negedge clk);
        chk("full_blocks", blocks_sent, 16'd11);
        next_cycle();

        // Pointer wrap: ten blocks, random tready
        pushed = 0; got = 0; cyc = 0;
        while ((got < 40) && (cyc < 600)) begin
            in_valid = (pushed < 10);
            in_block = pat(pushed);
            in_last  = (pushed == 9);
            tready   = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (in_valid && in_ready) pushed++;
            if (tvalid && tready) begin
                chk("wrap_tdata", tdata, wrd(pat(got / 4), got % 4));
                chk("wrap_tlast", tlast, got == 39);
                got++;
            end
            cyc++;
            next_cycle();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("wrap_beats", got, 40);
        @(negedge clk);
        chk("wrap_blocks", blocks_sent, 16'd21);
        next_cycle();

        // Reset after beat 2 of a block
        tready = 1'b1;
        g = 128'h99990000_99990001_99990002_99990003;
        h = 128'h77770000_77770001_77770002_77770003;
        push_blk(g, 1'b1);
        expect_beat("r_g0", wrd(g, 0), 1'b0);
        expect_beat("r_g1", wrd(g, 1), 1'b0);
        areset = 1'b1;
        @(negedge clk);
        chk("r_in_ready", in_ready, 1'b0);
        next_cycle();
        areset = 1'b0;
        @(negedge clk);
        chk("r_tvalid", tvalid, 1'b0);
        chk("r_tlast", tlast, 1'b0);
        chk("r_blocks", blocks_sent, 16'd0);
        next_cycle();
        push_blk(h, 1'b1);
        for (int unsigned j = 0; j < 4; j++) expect_beat("r_h", wrd(h, j), j == 3);
        @(negedge clk);
        chk("r_after_blocks", blocks_sent, 16'd1);
        chk("r_after_idle", tvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_axis_out_serializer.md
# aes_axis_out_serializer

Output stage of the AES core. It accepts 128-bit result blocks from the cipher datapath, buffers them in a small block FIFO, and serializes each block into four 32-bit AXI-Stream beats. It asserts `m00_axis_tlast` on the final beat of the packet's last block. It drives the master side that the stream sink / DMA S2MM channel consumes.

## Interface
Parameters:
- `C_M_AXIS_TDATA_WIDTH`, 32: stream width; only 32 supported.
- `BLOCK_WIDTH`, 128: AES block width; only 128 supported.
- `FIFO_DEPTH`, 4: block FIFO depth in blocks; power of two, ≥ 2.

Ports:
- `m00_axis_aclk`, input, 1: the single clock.
- `m00_axis_areset`, input, 1: reset; synchronous, active-high.
- `in_valid`, input, 1: `in_block` / `in_last` valid.
- `in_ready`, output, 1: serializer can accept a block.
- `in_block`, input, 128: AES result block, big-endian word order.
- `in_last`, input, 1: block is the last of its packet.
- `m00_axis_tvalid`, output, 1: beat valid.
- `m00_axis_tready`, input, 1: downstream accepts beat.
- `m00_axis_tdata`, output, 32: beat data.
- `m00_axis_tstrb`, output, 4: byte strobes; constant 4'hF.
- `m00_axis_tlast`, output, 1: final beat of packet.
- `blocks_sent`, output, 16: count of fully transmitted blocks; wraps modulo 2^16.

## Operation
- Block FIFO: `FIFO_DEPTH` entries of {`in_last`, `in_block`}. Write pointer, read pointer and occupancy count are each log2(`FIFO_DEPTH`)+1 bits wide. Pointers wrap modulo `FIFO_DEPTH`.
- Push on `in_valid && in_ready`. `in_ready = !full && !m00_axis_areset`.
- `word_idx` (2 bits) selects the beat of the head block:
  - idx 0 → `block[127:96]`
  - idx 1 → `[95:64]`
  - idx 2 → `[63:32]`
  - idx 3 → `[31:0]`
- Beat handshake is `m00_axis_tvalid && m00_axis_tready`. On each handshake `word_idx` increments.
- On the handshake at idx 3: `word_idx` returns to 0, the head block is popped, and `blocks_sent` increments.
- `m00_axis_tvalid = !empty`. `m00_axis_tlast = head.last && word_idx == 3`.
- State machine:
  - IDLE (FIFO empty): goes to SEND when count becomes non-zero.
  - SEND: issues beats. Returns to IDLE after the pop that leaves the FIFO empty. Otherwise stays in SEND and continues with the next block at idx 0 with no bubble.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- When full, `in_ready` is low even if a pop occurs in the same cycle. There is no push-through at full.
- Packets are not length-limited. A packet with no `in_last` streams indefinitely without `tlast`.

## Timing
- Reset values: `m00_axis_tvalid` 0, `m00_axis_tlast` 0, `m00_axis_tdata` 0, `blocks_sent` 0, `word_idx` 0, pointers/count 0. `in_ready` is 0 while reset is asserted and 1 in the first cycle after release.
- Latency: a block pushed at edge N gives `m00_axis_tvalid` = 1 with beat 0 during cycle N+1 (registered FIFO write, first-word fall-through read).
- Throughput: one beat per cycle with `tready` held high. One block is accepted every 4 cycles at steady state.
- AXI rule: once `tvalid` is high, `tvalid`, `tdata` and `tlast` stay stable until the handshake. `tready` may toggle freely and has no combinational path to `tvalid`.
- `blocks_sent` updates on the edge of the idx-3 handshake.
- Reset mid-packet: all stored blocks are discarded and the partial block is abandoned. `tvalid` is 0 on the cycle after reset is sampled. No `tlast` is emitted for the abandoned packet.
- Data is combinationally muxed from registered storage. No output register stage is allowed to add latency.

## Test plan
- Single block `0x00112233_44556677_8899AABB_CCDDEEFF` with `in_last` = 1 and `tready` = 1:
  - beats are 00112233, 44556677, 8899AABB, CCDDEEFF on consecutive cycles starting at N+1;
  - `tlast` is high only on the 4th beat;
  - `blocks_sent` = 1.
- Three-block packet with `in_last` only on block 3 and `tready` = 1: 12 contiguous beats, `tlast` only on beat 12, no idle cycles.
- Backpressure: `tready` pattern 1,0,0,1 repeating during a 2-block transfer. Data and `tlast` are held stable while stalled. All 8 beats arrive in order.
- Full FIFO: `tready` = 0 and 5 blocks offered. `in_ready` drops after the 4th push and the 5th block is not accepted. Raising `tready` completes 4 beats, and `in_ready` returns the cycle after the pop.
- Pointer wrap: 10 blocks with incrementing pattern, `tready` random at 50%. 40 beats arrive in order and `blocks_sent` = 10.
- Reset after beat 2 of a block: `tvalid` is 0 next cycle and `blocks_sent` = 0. A following block streams correctly starting at beat 0.
